pipe_reg_elastic: RTL and testbench

PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

---
 rtl/pipe_reg_elastic_pkg.sv | 8 +
 rtl/pipe_reg_entry.sv | 27 ++
 rtl/pipe_reg_elastic.sv | 59 +++++
 tb/tb_pipe_reg_elastic.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_elastic_pkg.sv
// pipe_reg_elastic_pkg: shared payload-width and counter-width constants
package pipe_reg_elastic_pkg;
  localparam int WORD_LEN = 32;
  localparam int INSTRUCTION_LEN = 32;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/pipe_reg_entry.sv
// pipe_reg_entry: one valid/payload register pair with load, clear and zero controls
module pipe_reg_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              zero,
  input  logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [DATA_W-1:0] q
);
  // clear beats load so a flush overrides any simultaneous transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (zero) q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end
  end
endmodule

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: two-entry skid pipeline register; PIPE_REG_PERF_CNT_EN adds stall/flush counters
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int DATA_W     = WORD_LEN,
  parameter int FLUSH_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output occ_t              occupancy
`ifdef PIPE_REG_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
`endif
);
  logic              skid_valid, in_xfer, out_xfer, main_load, main_clear, skid_load, skid_clear, zero;
  logic [DATA_W-1:0] skid_data, main_d;
  assign in_ready   = ~skid_valid;
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign zero       = flush & (FLUSH_ZERO != 0);
  // a draining main refills from skid first, otherwise straight from the input
  assign main_d     = skid_valid ? skid_data : in_data;
  assign main_load  = (out_xfer & skid_valid) | (in_xfer & (~out_valid | out_xfer));
  assign main_clear = flush | (out_xfer & ~main_load);
  assign skid_load  = in_xfer & out_valid & ~out_xfer;
  assign skid_clear = flush | (out_xfer & skid_valid);
  assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};

  pipe_reg_entry #(.DATA_W(DATA_W)) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clear(main_clear), .zero(zero),
    .data(main_d), .valid(out_valid), .q(out_data)
  );

  pipe_reg_entry #(.DATA_W(DATA_W)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear), .zero(zero),
    .data(in_data), .valid(skid_valid), .q(skid_data)
  );

`ifdef PIPE_REG_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (out_valid || skid_valid) && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: directed and randomised checks of pipe_reg_elastic
module tb_pipe_reg_elastic;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic        iv1, ir1, ov1, or1;
  logic [0:0]  id1, od1;
  logic [1:0]  oc1;
  logic        iv2, ir2, ov2, or2;
  logic [255:0] id2, od2;
  logic [1:0]  oc2;
  int tests = 0;
  int fails = 0;
`ifdef PIPE_REG_PERF_CNT_EN
  logic [31:0] stall_cnt, sc1, sc2;
  logic [15:0] flush_cnt, fc1, fc2;
`endif

  pipe_reg_elastic dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_REG_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_reg_elastic #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1)
`ifdef PIPE_REG_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  pipe_reg_elastic #(.DATA_W(256)) dut256 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(iv2), .in_ready(ir2),
    .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(oc2)
`ifdef PIPE_REG_PERF_CNT_EN
    , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    iv1 = 1'b0; id1 = '0; or1 = 1'b0; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = exp_d[0];
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid !== 1'b1 || out_data !== exp_d[i])
        begin fails++; $display("FAIL stream_data[%0d] got v=%0b d=%0h exp v=1 d=%0h", i, out_valid, out_data, exp_d[i]); end
      tests++; if (occupancy > 2'd1) begin fails++; $display("FAIL stream_occ[%0d] got %0d exp <=1", i, occupancy); end
      if (i < 2) in_data = exp_d[i+1]; else in_valid = 1'b0;
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ got %0d exp 2", occupancy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
    step();
    tests++; if (out_data !== 32'hA || occupancy !== 2'd2) begin fails++; $display("FAIL bp_stable got d=%0h occ=%0d exp d=a occ=2", out_data, occupancy); end
    out_ready = 1'b1;
    #1;
    tests++; if (out_data !== 32'hA) begin fails++; $display("FAIL bp_first got %0h exp a", out_data); end
    step();
    tests++; if (out_data !== 32'hB || out_valid !== 1'b1) begin fails++; $display("FAIL bp_second got v=%0b d=%0h exp v=1 d=b", out_valid, out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_back got %0b exp 1", in_ready); end
    step();
    tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL bp_empty got %0d exp 0", occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_full got occ=%0d v=%0b exp occ=0 v=0", occupancy, out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL flush_zero got %0h exp 0", out_data); end
    in_valid = 1'b1; in_data = 32'hD;
    step();
    in_data = 32'hE; flush = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_discard[%0d] got v=%0b d=%0h exp v=0", i, out_valid, out_data); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    tests++; if (occupancy !== 2'd1) begin fails++; $display("FAIL ar_setup got %0d exp 1", occupancy); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL ar_immediate got v=%0b occ=%0d d=%0h rdy=%0b exp 0 0 0 1", out_valid, occupancy, out_data, in_ready); end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h66;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h66) begin fails++; $display("FAIL ar_first got v=%0b d=%0h exp v=1 d=66", out_valid, out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

`ifdef PIPE_REG_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    tests++; if (stall_cnt !== 32'd5) begin fails++; $display("FAIL perf_stall got %0d exp 5", stall_cnt); end
    tests++; if (flush_cnt !== 16'd1) begin fails++; $display("FAIL perf_flush got %0d exp 1", flush_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [0:0]   q1 [$];
    logic [255:0] q2 [$];
    logic [255:0] r;
    for (int c = 0; c < 10010; c++) begin
      @(posedge clk);
      #1;
      if (c < 10000) begin
        iv1 = 1'($urandom_range(1)); id1 = 1'($urandom); or1 = 1'($urandom_range(1));
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        iv2 = 1'($urandom_range(1)); id2 = r; or2 = 1'($urandom_range(1));
      end else begin
        iv1 = 1'b0; iv2 = 1'b0; or1 = 1'b1; or2 = 1'b1;
      end
      @(negedge clk);
      tests++; if (oc1 !== 2'(q1.size())) begin fails++; $display("FAIL rnd1_occ c=%0d got %0d exp %0d", c, oc1, q1.size()); end
      tests++; if (oc2 !== 2'(q2.size())) begin fails++; $display("FAIL rnd256_occ c=%0d got %0d exp %0d", c, oc2, q2.size()); end
      if (ov1 && or1) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL rnd1_extra c=%0d got %0h exp none", c, od1); end
        else begin
          if (od1 !== q1[0]) begin fails++; $display("FAIL rnd1_data c=%0d got %0h exp %0h", c, od1, q1[0]); end
          void'(q1.pop_front());
        end
      end
      if (ov2 && or2) begin
        tests++;
        if (q2.size() == 0) begin fails++; $display("FAIL rnd256_extra c=%0d got %0h exp none", c, od2); end
        else begin
          if (od2 !== q2[0]) begin fails++; $display("FAIL rnd256_data c=%0d got %0h exp %0h", c, od2, q2[0]); end
          void'(q2.pop_front());
        end
      end
      if (iv1 && ir1) q1.push_back(id1);
      if (iv2 && ir2) q2.push_back(id2);
    end
    tests++; if (q1.size() != 0 || q2.size() != 0) begin fails++; $display("FAIL rnd_lost got %0d/%0d pending exp 0/0", q1.size(), q2.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_REG_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
